wb_stage: RTL

//  Writeback/commit stage of the multi-cycle NPC core; the producing end of the wb->fetch interface.

---
 rtl/wb_stage_pkg.sv | 37 +++
 rtl/wb_csr.sv | 72 +++++++
 rtl/wb_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared constants and types for the writeback/commit stage: bus widths,
// machine trap CSR addresses, the writeback FSM state encoding and the
// field layout of the mem->wb bus.
// -----------------------------------------------------------------------------
package wb_stage_pkg;

  localparam int MEM_WB_BUS_WIDTH       = 150;
  localparam int WB_TO_DECODE_BUS_WIDTH = 33;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  typedef enum logic [1:0] {
    WB_BOOT   = 2'd0,
    WB_IDLE   = 2'd1,
    WB_COMMIT = 2'd2
  } wb_state_e;

  // Field order is MSB->LSB exactly as the memory stage packs the bus.
  typedef struct packed {
    logic [31:0] pc;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] rd_wdata;
    logic        jmp_flag;
    logic [31:0] jmp_target;
    logic        ecall;
    logic        mret;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
  } mem_wb_bus_t;

endpackage

// File: rtl/wb_csr.sv
// -----------------------------------------------------------------------------
// wb_csr
// Machine trap CSRs (mtvec, mepc, mcause) owned by the writeback stage.
// Ports:
//   clk_i, rst_n_i           clock / asynchronous active-low reset
//   i_we, i_waddr, i_wdata   software CSR write port (unknown addresses dropped)
//   i_trap, i_trapPc,
//   i_trapCause              ecall trap update (overrides writes to mepc/mcause)
//   i_raddr, o_rdata         combinational read port, 0 for unimplemented CSRs
//   o_mtvec, o_mepc          current values for the redirect mux
// -----------------------------------------------------------------------------
module wb_csr
  import wb_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        i_we,
  input  logic [11:0] i_waddr,
  input  logic [31:0] i_wdata,
  input  logic        i_trap,
  input  logic [31:0] i_trapPc,
  input  logic [31:0] i_trapCause,
  input  logic [11:0] i_raddr,
  output logic [31:0] o_rdata,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc
);

  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;

  // CSR registers. A trap owns mepc/mcause for its cycle, but a write to
  // mtvec in the same instruction still lands.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mtvec  <= '0;
      r_mepc   <= '0;
      r_mcause <= '0;
    end else begin
      if (i_we && (i_waddr == CSR_MTVEC)) begin
        r_mtvec <= i_wdata;
      end
      if (i_trap) begin
        r_mepc   <= i_trapPc;
        r_mcause <= i_trapCause;
      end else if (i_we) begin
        if (i_waddr == CSR_MEPC) begin
          r_mepc <= i_wdata;
        end
        if (i_waddr == CSR_MCAUSE) begin
          r_mcause <= i_wdata;
        end
      end
    end
  end

  // Read port sees registered values only; no bypass of a same-cycle write.
  always_comb begin
    o_rdata = '0;
    case (i_raddr)
      CSR_MTVEC:  o_rdata = r_mtvec;
      CSR_MEPC:   o_rdata = r_mepc;
      CSR_MCAUSE: o_rdata = r_mcause;
      default:    o_rdata = '0;
    endcase
  end

  assign o_mtvec = r_mtvec;
  assign o_mepc  = r_mepc;

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback/commit stage of the multi-cycle NPC core. Retires one instruction
// per mem_wb_valid_i pulse, performs RF and CSR writes, resolves ecall/mret/
// jump redirects and pulses wb_finish_o with wb_fetch_bus_o to fetch. After
// every reset release a single boot redirect to RESET_PC is issued.
// Ports:
//   clk_i, rst_n_i                     clock / asynchronous active-low reset
//   mem_wb_valid_i, mem_wb_bus_i       completed instruction from memory stage
//   rf_we_o, rf_waddr_o, rf_wdata_o    register-file write port
//   csr_raddr_i, csr_rdata_o           combinational CSR read port
//   wb_finish_o, wb_fetch_bus_o        retire/boot pulse and {jmp_flag, target}
// Optional macro WB_DIFFTEST_EN adds commit_valid_o, commit_pc_o, commit_npc_o.
// -----------------------------------------------------------------------------
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              mem_wb_valid_i,
  input  logic [MEM_WB_BUS_WIDTH-1:0]       mem_wb_bus_i,
  output logic                              rf_we_o,
  output logic [4:0]                        rf_waddr_o,
  output logic [31:0]                       rf_wdata_o,
  input  logic [11:0]                       csr_raddr_i,
  output logic [31:0]                       csr_rdata_o,
  output logic                              wb_finish_o,
  output logic [WB_TO_DECODE_BUS_WIDTH-1:0] wb_fetch_bus_o
`ifdef WB_DIFFTEST_EN
  ,
  output logic                              commit_valid_o,
  output logic [31:0]                       commit_pc_o,
  output logic [31:0]                       commit_npc_o
`endif
);

  wb_state_e   r_state;
  wb_state_e   w_nextState;
  logic        r_live;
  mem_wb_bus_t r_bus;

  logic        w_csrWe;
  logic        w_trap;
  logic [31:0] w_mtvec;
  logic [31:0] w_mepc;

  // r_live is low for the first cycle after release so that BOOT, which is
  // also the reset state, drives nothing while reset is held and issues its
  // pulse in the cycle after the first clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= WB_BOOT;
      r_live  <= 1'b0;
      r_bus   <= '0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_nextState;
      if ((r_state == WB_IDLE) && mem_wb_valid_i) begin
        r_bus <= mem_wb_bus_t'(mem_wb_bus_i);
      end
    end
  end

  // Next-state and output decode. Valid in BOOT or COMMIT is deliberately
  // ignored; fetch never issues before seeing wb_finish_o.
  always_comb begin
    w_nextState    = r_state;
    wb_finish_o    = 1'b0;
    wb_fetch_bus_o = '0;
    rf_we_o        = 1'b0;
    rf_waddr_o     = '0;
    rf_wdata_o     = '0;
    w_csrWe        = 1'b0;
    w_trap         = 1'b0;
    case (r_state)
      WB_BOOT: begin
        if (r_live) begin
          wb_finish_o    = 1'b1;
          wb_fetch_bus_o = {1'b1, RESET_PC};
          w_nextState    = WB_IDLE;
        end
      end
      WB_IDLE: begin
        if (mem_wb_valid_i) begin
          w_nextState = WB_COMMIT;
        end
      end
      WB_COMMIT: begin
        wb_finish_o = 1'b1;
        rf_we_o     = r_bus.rd_we & (r_bus.rd != 5'd0) & ~r_bus.ecall;
        rf_waddr_o  = r_bus.rd;
        rf_wdata_o  = r_bus.rd_wdata;
        w_csrWe     = r_bus.csr_we;
        w_trap      = r_bus.ecall;
        // Redirect uses pre-write CSR values.
        if (r_bus.ecall) begin
          wb_fetch_bus_o = {1'b1, w_mtvec};
        end else if (r_bus.mret) begin
          wb_fetch_bus_o = {1'b1, w_mepc};
        end else if (r_bus.jmp_flag) begin
          wb_fetch_bus_o = {1'b1, r_bus.jmp_target};
        end
        w_nextState = WB_IDLE;
      end
      default: begin
        w_nextState = WB_BOOT;
      end
    endcase
  end

  wb_csr u_csr (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .i_we        (w_csrWe),
    .i_waddr     (r_bus.csr_addr),
    .i_wdata     (r_bus.csr_wdata),
    .i_trap      (w_trap),
    .i_trapPc    (r_bus.pc),
    .i_trapCause (ECALL_CAUSE),
    .i_raddr     (csr_raddr_i),
    .o_rdata     (csr_rdata_o),
    .o_mtvec     (w_mtvec),
    .o_mepc      (w_mepc)
  );

`ifdef WB_DIFFTEST_EN
  // Difftest commit record, valid only while committing.
  always_comb begin
    commit_valid_o = 1'b0;
    commit_pc_o    = '0;
    commit_npc_o   = '0;
    if (r_state == WB_COMMIT) begin
      commit_valid_o = 1'b1;
      commit_pc_o    = r_bus.pc;
      commit_npc_o   = wb_fetch_bus_o[32] ? wb_fetch_bus_o[31:0] : (r_bus.pc + 32'd4);
    end
  end
`endif

endmodule
